// File: rtl/reg_bus_master.sv
// Register-bus initiator: parses 'W'/'R' byte commands from an rx stream, runs single bus
// writes/reads and returns an ack or read byte on tx. Optional inter-byte timeout: REG_BUS_TIMEOUT_EN.
module reg_bus_master #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic [ADDR_WIDTH-1:0] o_bus_addr,
    output logic [DATA_WIDTH-1:0] o_bus_wdata,
    output logic                  o_bus_wr,
    input  logic [DATA_WIDTH-1:0] i_bus_rdata,
    output logic                  o_busy
);

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;
    localparam logic [7:0] RSP_TMO = 8'h54;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_BUS_WR,
        S_BUS_RD,
        S_RD_WAIT,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_op_wr;
    logic [ADDR_WIDTH-1:0] r_bus_addr;
    logic [DATA_WIDTH-1:0] r_bus_wdata;
    logic [7:0]            r_tx_data;
    logic                  r_tx_valid;
    logic                  r_bus_wr;
    logic                  r_busy;
    logic                  r_rx_ready;
    logic                  w_rx_fire;
    logic                  w_op_load;
    logic                  w_addr_load;
    logic                  w_wdata_load;
    logic                  w_tx_load;
    logic [7:0]            w_tx_byte;
    logic                  w_tmo;

    assign w_rx_fire = i_rx_valid & r_rx_ready;

`ifdef REG_BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             w_in_get;

    assign w_in_get = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA);
    assign w_tmo    = w_in_get && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter while waiting for the next command byte.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tmo_cnt <= '0;
        end else if (w_rx_fire || !w_in_get) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
        end
    end
`else
    // Without the timeout the GET states wait forever; the parameter only shapes the interface.
    localparam bit TMO_EN = 1'b0;
    assign w_tmo = TMO_EN && (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_op_load    = 1'b0;
        w_addr_load  = 1'b0;
        w_wdata_load = 1'b0;
        w_tx_load    = 1'b0;
        w_tx_byte    = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (w_rx_fire) begin
                    if ((i_rx_data == OP_WR) || (i_rx_data == OP_RD)) begin
                        w_op_load   = 1'b1;
                        w_state_nxt = S_GET_ADDR;
                    end else begin
                        w_tx_load   = 1'b1;
                        w_tx_byte   = RSP_ERR;
                        w_state_nxt = S_RESP;
                    end
                end
            end
            S_GET_ADDR: begin
                if (w_rx_fire) begin
                    w_addr_load = 1'b1;
                    w_state_nxt = r_op_wr ? S_GET_DATA : S_BUS_RD;
                end else if (w_tmo) begin
                    w_tx_load   = 1'b1;
                    w_tx_byte   = RSP_TMO;
                    w_state_nxt = S_RESP;
                end
            end
            S_GET_DATA: begin
                if (w_rx_fire) begin
                    w_wdata_load = 1'b1;
                    w_state_nxt  = S_BUS_WR;
                end else if (w_tmo) begin
                    w_tx_load   = 1'b1;
                    w_tx_byte   = RSP_TMO;
                    w_state_nxt = S_RESP;
                end
            end
            S_BUS_WR: begin
                w_tx_load   = 1'b1;
                w_tx_byte   = RSP_ACK;
                w_state_nxt = S_RESP;
            end
            S_BUS_RD: begin
                w_state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // Responder output is registered, so read data is valid in this cycle.
                w_tx_load   = 1'b1;
                w_tx_byte   = 8'(i_bus_rdata);
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (i_tx_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and state-decoded outputs, registered from the next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op_wr     <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_tx_data   <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_bus_wr    <= 1'b0;
            r_busy      <= 1'b0;
            r_rx_ready  <= 1'b0;
        end else begin
            if (w_op_load) begin
                r_op_wr <= (i_rx_data == OP_WR);
            end
            if (w_addr_load) begin
                r_bus_addr <= i_rx_data[ADDR_WIDTH-1:0];
            end
            if (w_wdata_load) begin
                r_bus_wdata <= i_rx_data[DATA_WIDTH-1:0];
            end
            if (w_tx_load) begin
                r_tx_data <= w_tx_byte;
            end
            r_tx_valid <= (w_state_nxt == S_RESP);
            r_bus_wr   <= (w_state_nxt == S_BUS_WR);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_rx_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_GET_ADDR) ||
                          (w_state_nxt == S_GET_DATA);
        end
    end

    assign o_rx_ready  = r_rx_ready;
    assign o_tx_data   = r_tx_data;
    assign o_tx_valid  = r_tx_valid;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_wdata = r_bus_wdata;
    assign o_bus_wr    = r_bus_wr;
    assign o_busy      = r_busy;

endmodule
